// File: rtl/kernel_sched_pkg.sv
// Shared definitions for the kernel-memory read sequencer: geometry of a
// kernel word, the kernel_mem read latency and the sequencer state encoding.
package kernel_sched_pkg;

    localparam int GROUP_NB   = 4;
    localparam int KER_WIDTH  = 16;
    localparam int MEM_AWIDTH = 8;
    localparam int REP_WIDTH  = 16;
    localparam int WORD_W     = GROUP_NB * KER_WIDTH;

    // Cycles from rd_addr_set until kernel_mem presents the word at the base
    // address; must track kernel_mem's read pipeline.
    localparam int PRIME_CYC  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_PRIME  = 3'd2,
        ST_STREAM = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

endpackage

// File: rtl/kernel_sched_if.sv
// Job/config handshake and kernel-word stream between the control side
// (master: regfile + convolution engine) and the sequencer (slave).
//
// Handshake: a transfer happens on a clock edge where valid & ready are both
// high. Once valid is raised, the data and side-band (out_last) stay stable
// until the transfer; ready may change freely and never depends on valid
// combinationally from the sequencer side.
interface kernel_sched_if;
    import kernel_sched_pkg::*;

    logic [MEM_AWIDTH-1:0] cfg_base;
    logic [MEM_AWIDTH-1:0] cfg_len_m1;
    logic [REP_WIDTH-1:0]  cfg_rep_m1;
    logic                  cfg_val;
    logic                  cfg_rdy;

    logic [WORD_W-1:0]     out_data;
    logic                  out_val;
    logic                  out_rdy;
    logic                  out_last;
    logic                  done;

    modport master (
        output cfg_base, cfg_len_m1, cfg_rep_m1, cfg_val, out_rdy,
        input  cfg_rdy, out_data, out_val, out_last, done
    );

    modport slave (
        input  cfg_base, cfg_len_m1, cfg_rep_m1, cfg_val, out_rdy,
        output cfg_rdy, out_data, out_val, out_last, done
    );

endinterface

// File: rtl/kernel_sched.sv
// Read-side sequencer for kernel_mem. Takes one job (base, length, repeat
// count), reloads the read pointer at the start of every pass and replays the
// kernel region as a valid/ready stream. Data is passed straight through from
// kernel_mem; kernel_mem advances its own pointer on every pop.
module kernel_sched
    import kernel_sched_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    kernel_sched_if.slave         bus,
    input  logic                  abort,
    input  logic                  wr_busy,
    output logic [MEM_AWIDTH-1:0] ker_rd_addr,
    output logic                  ker_rd_set,
    input  logic [WORD_W-1:0]     ker_rd_data,
    output logic                  ker_rd_pop,
    output state_e                dbg_state
);

    localparam int PRIME_W = $clog2(PRIME_CYC + 1);

    state_e                state_q;
    logic [MEM_AWIDTH-1:0] base_q;
    logic [MEM_AWIDTH-1:0] len_q;
    logic [REP_WIDTH-1:0]  rep_q;
    logic [MEM_AWIDTH-1:0] word_cnt_q;
    logic [REP_WIDTH-1:0]  rep_cnt_q;
    logic [PRIME_W-1:0]    prime_q;
    logic                  done_q;

    logic                  xfer;
    logic                  last_word;

    // A word leaves when the engine takes it; the last word of a pass is
    // identified purely by the in-pass word counter.
    assign xfer      = (state_q == ST_STREAM) && bus.out_rdy;
    assign last_word = (word_cnt_q == len_q);

    // Sequencer FSM and its counters; abort overrides every transition.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            len_q      <= '0;
            rep_q      <= '0;
            word_cnt_q <= '0;
            rep_cnt_q  <= '0;
            prime_q    <= '0;
            done_q     <= 1'b0;
        end else if (abort) begin
            state_q    <= ST_IDLE;
            word_cnt_q <= '0;
            rep_cnt_q  <= '0;
            prime_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.cfg_val) begin
                        base_q     <= bus.cfg_base;
                        len_q      <= bus.cfg_len_m1;
                        rep_q      <= bus.cfg_rep_m1;
                        word_cnt_q <= '0;
                        rep_cnt_q  <= '0;
                        state_q    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // Pointer load is held off while the write side owns kernel_mem.
                    if (!wr_busy) begin
                        prime_q <= '0;
                        state_q <= ST_PRIME;
                    end
                end
                ST_PRIME: begin
                    if (prime_q == PRIME_W'(PRIME_CYC - 1)) begin
                        prime_q <= '0;
                        state_q <= ST_STREAM;
                    end else begin
                        prime_q <= prime_q + PRIME_W'(1);
                    end
                end
                ST_STREAM: begin
                    if (xfer) begin
                        if (last_word) begin
                            word_cnt_q <= '0;
                            if (rep_cnt_q == rep_q) begin
                                done_q  <= 1'b1;
                                state_q <= ST_DONE;
                            end else begin
                                // Every pass restarts from base, so reload the pointer.
                                rep_cnt_q <= rep_cnt_q + REP_WIDTH'(1);
                                state_q   <= ST_LOAD;
                            end
                        end else begin
                            word_cnt_q <= word_cnt_q + MEM_AWIDTH'(1);
                        end
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Output decode from the registered state; stream data is a pass-through.
    assign bus.cfg_rdy  = (state_q == ST_IDLE);
    assign bus.out_val  = (state_q == ST_STREAM);
    assign bus.out_data = ker_rd_data;
    assign bus.out_last = (state_q == ST_STREAM) && last_word;
    assign bus.done     = done_q;

    // kernel_mem read-side controls.
    assign ker_rd_addr = base_q;
    assign ker_rd_set  = (state_q == ST_LOAD) && !wr_busy && !abort;
    assign ker_rd_pop  = (state_q == ST_STREAM) && bus.out_rdy;

    assign dbg_state = state_q;

endmodule

// File: tb/tb_kernel_sched.sv
// Bench for kernel_sched with a behavioural kernel_mem model. Expected words
// come from a job-level model: every pass replays mem[base .. base+len] with
// addresses wrapping mod 256, out_last on the final word of each pass, and one
// done pulse the cycle after the final word of the job.
module tb_kernel_sched;
    import kernel_sched_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    kernel_sched_if bus_if();

    logic                  abort   = 1'b0;
    logic                  wr_busy = 1'b0;
    logic [MEM_AWIDTH-1:0] ker_rd_addr;
    logic                  ker_rd_set;
    logic [WORD_W-1:0]     ker_rd_data;
    logic                  ker_rd_pop;
    state_e                dbg_state;

    kernel_sched dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus_if),
        .abort       (abort),
        .wr_busy     (wr_busy),
        .ker_rd_addr (ker_rd_addr),
        .ker_rd_set  (ker_rd_set),
        .ker_rd_data (ker_rd_data),
        .ker_rd_pop  (ker_rd_pop),
        .dbg_state   (dbg_state)
    );

    // ---------------- kernel_mem model ----------------
    logic [WORD_W-1:0] mem [256];
    logic [7:0]        mem_ptr    = 8'd0;
    int                prime_left = 0;

    always @(posedge clk) begin
        if (ker_rd_set) begin
            mem_ptr    <= ker_rd_addr;
            prime_left <= PRIME_CYC;
        end else begin
            if (ker_rd_pop) mem_ptr <= mem_ptr + 8'd1;
            if (prime_left != 0) prime_left <= prime_left - 1;
        end
    end
    assign ker_rd_data = (prime_left != 0) ? {4{16'hDEAD}} : mem[mem_ptr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [WORD_W-1:0] exp_q[$];
    bit                last_q[$];
    int                exp_idx   = 0;
    int                xfer_cyc[$];
    int                xfer_cnt  = 0;
    int                done_cnt  = 0;
    int                pop_cnt   = 0;
    int                set_cnt   = 0;
    int                rdy_mode  = 0;
    int                total     = 0;
    int                bad       = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Observes every cycle at the falling edge, i.e. what the next rising edge will see.
    task automatic monitor_loop();
        logic [63:0] held_data = '0;
        logic        held_last = 1'b0;
        bit          stall_prev = 0;
        bit          done_pend  = 0;
        bit          abort_chk  = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_idx    = exp_q.size();
                stall_prev = 0;
                done_pend  = 0;
                abort_chk  = 0;
                continue;
            end
            if (abort_chk) begin
                chk("abort_out_val", 64'(bus_if.out_val), 64'd0);
                chk("abort_cfg_rdy", 64'(bus_if.cfg_rdy), 64'd1);
                abort_chk = 0;
            end
            if (stall_prev) begin
                chk("hold_data", bus_if.out_data, held_data);
                chk("hold_last", 64'(bus_if.out_last), 64'(held_last));
            end
            if (bus_if.done || done_pend) chk("done_pulse", 64'(bus_if.done), 64'(done_pend));
            if (bus_if.done) done_cnt++;
            done_pend = 0;
            if (wr_busy) chk("set_while_busy", 64'(ker_rd_set), 64'd0);
            if (ker_rd_set) set_cnt++;
            if (ker_rd_pop) pop_cnt++;
            if (bus_if.out_val && bus_if.out_rdy) begin
                xfer_cnt++;
                xfer_cyc.push_back(cyc);
                if (exp_idx >= exp_q.size()) begin
                    chk("spurious_word", 64'(bus_if.out_val), 64'd0);
                end else begin
                    chk("word_data", bus_if.out_data, exp_q[exp_idx]);
                    chk("word_last", 64'(bus_if.out_last), 64'(last_q[exp_idx]));
                    exp_idx++;
                    if (exp_idx == exp_q.size() && !abort) done_pend = 1;
                end
            end
            stall_prev = bus_if.out_val && !bus_if.out_rdy && !abort;
            held_data  = bus_if.out_data;
            held_last  = bus_if.out_last;
            if (abort) begin
                exp_idx   = exp_q.size();
                abort_chk = 1;
                stall_prev = 0;
            end
        end
    endtask

    // Engine-side ready pattern: 0 always ready, 1 repeating 1,0,0, 2 random.
    task automatic rdy_driver();
        int ph = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus_if.out_rdy = 1'b1;
                1:       begin bus_if.out_rdy = (ph % 3 == 0); ph++; end
                default: bus_if.out_rdy = 1'($urandom_range(0, 1));
            endcase
        end
    endtask

    task automatic submit(input logic [7:0] base, input logic [7:0] len_m1, input logic [15:0] rep_m1);
        bit ok = 0;
        for (int r = 0; r <= int'(rep_m1); r++) begin
            for (int i = 0; i <= int'(len_m1); i++) begin
                logic [7:0] a;
                a = base + 8'(i);
                exp_q.push_back(mem[a]);
                last_q.push_back(i == int'(len_m1));
            end
        end
        @(posedge clk);
        #1;
        bus_if.cfg_base   = base;
        bus_if.cfg_len_m1 = len_m1;
        bus_if.cfg_rep_m1 = rep_m1;
        bus_if.cfg_val    = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus_if.cfg_rdy) begin ok = 1; break; end
        end
        chk("cfg_accept", 64'(ok), 64'd1);
        @(posedge clk);
        #1;
        bus_if.cfg_val = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        bit seen = 0;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk);
            if (done_cnt > d0) begin seen = 1; break; end
        end
        chk("job_done", 64'(seen), 64'd1);
        @(posedge clk);
        chk("queue_drained", 64'(exp_idx), 64'(exp_q.size()));
    endtask

    task automatic run_job(input logic [7:0] base, input logic [7:0] len_m1, input logic [15:0] rep_m1);
        int d0;
        d0 = done_cnt;
        submit(base, len_m1, rep_m1);
        wait_done(d0);
    endtask

    initial begin
        int d0;
        int s0;
        int x0;
        bit job_over;
        bit seen;

        bus_if.cfg_base   = '0;
        bus_if.cfg_len_m1 = '0;
        bus_if.cfg_rep_m1 = '0;
        bus_if.cfg_val    = 1'b0;
        bus_if.out_rdy    = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
        for (int i = 0; i < 10; i++) mem[i] = 64'(i + 1);

        fork
            monitor_loop();
            rdy_driver();
        join_none

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cfg_rdy", 64'(bus_if.cfg_rdy), 64'd1);
        chk("rst_out_val", 64'(bus_if.out_val), 64'd0);
        chk("rst_out_last", 64'(bus_if.out_last), 64'd0);
        chk("rst_done", 64'(bus_if.done), 64'd0);
        chk("rst_rd_set", 64'(ker_rd_set), 64'd0);
        chk("rst_rd_pop", 64'(ker_rd_pop), 64'd0);
        chk("rst_rd_addr", 64'(ker_rd_addr), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        @(posedge clk);
        #3 rst = 1'b1;

        // Single pass of 10 words at full rate.
        rdy_mode = 0;
        pop_cnt = 0;
        xfer_cyc.delete();
        d0 = done_cnt;
        run_job(8'd0, 8'd9, 16'd0);
        chk("t1_count", 64'(xfer_cyc.size()), 64'd10);
        for (int k = 1; k < xfer_cyc.size(); k++)
            chk("t1_spacing", 64'(xfer_cyc[k] - xfer_cyc[k-1]), 64'd1);
        chk("t1_done_once", 64'(done_cnt - d0), 64'd1);
        chk("t1_pops", 64'(pop_cnt), 64'd10);

        // Three passes of 4,5,6; cfg_val raised mid-job must be ignored.
        xfer_cyc.delete();
        d0 = done_cnt;
        s0 = set_cnt;
        fork
            run_job(8'd3, 8'd2, 16'd2);
            begin
                repeat (8) @(posedge clk);
                #1;
                bus_if.cfg_base = 8'd77;
                bus_if.cfg_val  = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                bus_if.cfg_val  = 1'b0;
            end
        join
        chk("t2_count", 64'(xfer_cyc.size()), 64'd9);
        for (int k = 1; k < xfer_cyc.size(); k++)
            chk("t2_spacing", 64'(xfer_cyc[k] - xfer_cyc[k-1]), (k % 3 == 0) ? 64'd4 : 64'd1);
        chk("t2_done_once", 64'(done_cnt - d0), 64'd1);
        chk("t2_loads", 64'(set_cnt - s0), 64'd3);

        // Backpressure 1,0,0 pattern.
        rdy_mode = 1;
        pop_cnt = 0;
        run_job(8'd0, 8'd9, 16'd0);
        chk("t3_pops", 64'(pop_cnt), 64'd10);
        rdy_mode = 0;

        // Region straddling the top of the address space, two passes.
        run_job(8'd254, 8'd3, 16'd1);

        // wr_busy during LOAD holds off the pointer load.
        s0 = set_cnt;
        wr_busy = 1'b1;
        fork
            run_job(8'd20, 8'd4, 16'd0);
            begin
                repeat (7) @(posedge clk);
                #1 wr_busy = 1'b0;
            end
        join
        chk("t5_loads", 64'(set_cnt - s0), 64'd1);

        // Single-word passes.
        run_job(8'd40, 8'd0, 16'd3);

        // Abort on the 4th word: no done, back to IDLE, next job fine.
        d0 = done_cnt;
        x0 = xfer_cnt;
        submit(8'd0, 8'd9, 16'd0);
        seen = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            if (xfer_cnt >= x0 + 3) begin seen = 1; break; end
        end
        chk("t6_reach_word4", 64'(seen), 64'd1);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        repeat (6) @(posedge clk);
        chk("t6_no_done", 64'(done_cnt - d0), 64'd0);
        chk("t6_words", 64'(xfer_cnt - x0), 64'd4);
        chk("t6_state", 64'(dbg_state), 64'(ST_IDLE));
        run_job(8'd100, 8'd5, 16'd1);

        // cfg_val together with abort in IDLE drops the job.
        x0 = xfer_cnt;
        @(posedge clk);
        #1;
        bus_if.cfg_val = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        bus_if.cfg_val = 1'b0;
        abort = 1'b0;
        repeat (8) @(posedge clk);
        chk("drop_state", 64'(dbg_state), 64'(ST_IDLE));
        chk("drop_no_words", 64'(xfer_cnt - x0), 64'd0);

        // Random jobs with random backpressure and random wr_busy.
        rdy_mode = 2;
        for (int j = 0; j < 8; j++) begin
            logic [7:0]  b;
            logic [7:0]  l;
            logic [15:0] r;
            b = 8'($urandom_range(0, 255));
            l = 8'($urandom_range(0, 15));
            r = 16'($urandom_range(0, 3));
            job_over = 0;
            fork
                begin run_job(b, l, r); job_over = 1; end
                begin
                    while (!job_over) begin
                        @(posedge clk);
                        #1 wr_busy = ($urandom_range(0, 3) == 0);
                    end
                    wr_busy = 1'b0;
                end
            join
        end
        rdy_mode = 0;

        // Asynchronous reset mid-pass.
        x0 = xfer_cnt;
        submit(8'd50, 8'd20, 16'd0);
        seen = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            if (xfer_cnt >= x0 + 2) begin seen = 1; break; end
        end
        chk("rst_mid_reach", 64'(seen), 64'd1);
        #3 rst = 1'b0;
        #1;
        chk("arst_cfg_rdy", 64'(bus_if.cfg_rdy), 64'd1);
        chk("arst_out_val", 64'(bus_if.out_val), 64'd0);
        chk("arst_out_last", 64'(bus_if.out_last), 64'd0);
        chk("arst_rd_pop", 64'(ker_rd_pop), 64'd0);
        chk("arst_rd_addr", 64'(ker_rd_addr), 64'd0);
        chk("arst_state", 64'(dbg_state), 64'(ST_IDLE));
        @(posedge clk);
        #3 rst = 1'b1;
        run_job(8'd60, 8'd3, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
